restoring_divider_n_bit: RTL and testbench

- Iterative unsigned integer divider. It is the inverse of the team's ripple-carry adder datapath: it computes quotient and remainder by repeated trial subtraction.
- It runs one quotient bit per clock and uses a start/ready/done handshake.
- It is the first multi-cycle arithmetic block in the steps series. It sits beside the 4-bit adder and reuses full_adder cells for its subtractor.

---
 rtl/restoring_divider_n_bit.sv | 173 +++++++++++++++++
 tb/tb_restoring_divider_n_bit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider_n_bit.sv
// Iterative unsigned restoring divider: one quotient bit per clock with a
// start/ready/done handshake. Trial subtraction uses a ripple chain of
// full_adder cells (R' + ~{0,V} + 1).
//
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   start          begin a division (sampled only while ready=1)
//   dividend       numerator, captured on the accepting edge
//   divisor        denominator, captured on the accepting edge
//   ready          idle and able to accept start
//   done           one-cycle pulse when results are valid
//   quotient       result, held until the next completion
//   remainder      result, held until the next completion
//   divide_by_zero flag for the last completed operation

// One-bit full adder cell; outputs are combinational.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum_c,
  output logic carry_c
);

  assign sum_c   = a ^ b ^ cin;
  assign carry_c = (a & b) | (cin & (a ^ b));

endmodule

module restoring_divider_n_bit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divide_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] v;
  // The partial remainder is always < V after a restore, so its MSB is
  // always zero; only the low WIDTH bits are stored.
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [CW-1:0]    count;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   sub_b;
  logic [WIDTH:0]   diff;
  logic [WIDTH+1:0] carry;
  logic             no_borrow;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;
  logic             unused_diff_msb;

  // Trial subtraction R' - {0,V} through a ripple chain, carry_in = 1.
  assign r_shift  = {r, d[WIDTH-1]};
  assign sub_b    = ~{1'b0, v};
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH + 1; i++) begin : g_sub
    full_adder u_fa (
      .a       (r_shift[i]),
      .b       (sub_b[i]),
      .cin     (carry[i]),
      .sum_c   (diff[i]),
      .carry_c (carry[i+1])
    );
  end

  // Final carry-out high means no borrow: keep the difference.
  assign no_borrow       = carry[WIDTH+1];
  assign r_next          = no_borrow ? diff[WIDTH-1:0] : r_shift[WIDTH-1:0];
  assign q_next          = {q[WIDTH-2:0], no_borrow};
  // A kept difference is < V, so its MSB is never needed.
  assign unused_diff_msb = diff[WIDTH];

  // State register; ready/done are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ready <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      ready <= (state_next == IDLE);
      done  <= (state_next == DONE);
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (count == LAST) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d              <= '0;
      v              <= '0;
      r              <= '0;
      q              <= '0;
      count          <= '0;
      quotient       <= '0;
      remainder      <= '0;
      divide_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              quotient       <= '1;
              remainder      <= dividend;
              divide_by_zero <= 1'b1;
            end else begin
              d     <= dividend;
              v     <= divisor;
              r     <= '0;
              q     <= '0;
              count <= '0;
            end
          end
        end
        RUN: begin
          d     <= {d[WIDTH-2:0], 1'b0};
          r     <= r_next;
          q     <= q_next;
          count <= count + CW'(1);
          if (count == LAST) begin
            quotient       <= q_next;
            remainder      <= r_next;
            divide_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider_n_bit.sv
// Self-checking bench for restoring_divider_n_bit (WIDTH=4). Expected
// results come from a behavioural model pushed to a scoreboard queue at
// issue and popped when done is observed.
module tb_restoring_divider_n_bit;

  localparam int W   = 4;
  localparam int TMO = 40;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         ready;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         divide_by_zero;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  restoring_divider_n_bit #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .dividend       (dividend),
    .divisor        (divisor),
    .ready          (ready),
    .done           (done),
    .quotient       (quotient),
    .remainder      (remainder),
    .divide_by_zero (divide_by_zero)
  );

  always #5 clk = ~clk;

  // lat = index k of the first negedge after accept edge E_k at which done is high
  function automatic exp_t model(input int a, input int b);
    exp_t m;
    if (b == 0) begin
      m.q = '1; m.r = W'(a); m.dbz = 1'b1; m.lat = 0;
    end else begin
      m.q = W'(a / b); m.r = W'(a % b); m.dbz = 1'b0; m.lat = W;
    end
    return m;
  endfunction

  // Issue one operation and wait (bounded) for done; leaves time at the done negedge.
  task automatic run_op(input int a, input int b, output int lat, output bit got);
    @(negedge clk);
    start = 1'b1; dividend = W'(a); divisor = W'(b);
    sb.push_back(model(a, b));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    got = 1'b0; lat = -1;
    for (int k = 0; k <= TMO; k++) begin
      if (done) begin got = 1'b1; lat = k; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ready, done, quotient, remainder, divide_by_zero} !== {1'b1, 1'b0, W'(0), W'(0), 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b done=%b q=%0d r=%0d dbz=%b, required rdy=1 done=0 q=0 r=0 dbz=0",
               ready, done, quotient, remainder, divide_by_zero);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int   ta[3] = '{13, 5, 15};
    int   tb[3] = '{3, 7, 1};
    int   lat;
    bit   got;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], lat, got);
      e = sb.pop_front();
      checks++;
      if (!got || lat !== e.lat) begin
        errors++;
        $display("FAIL basic_latency %0d/%0d: got %0d (seen=%0b), required %0d", ta[i], tb[i], lat, got, e.lat);
      end
      checks++;
      if ({quotient, remainder, divide_by_zero} !== {e.q, e.r, e.dbz}) begin
        errors++;
        $display("FAIL basic_result %0d/%0d: got q=%0d r=%0d dbz=%b, required q=%0d r=%0d dbz=%b",
                 ta[i], tb[i], quotient, remainder, divide_by_zero, e.q, e.r, e.dbz);
      end
      @(negedge clk);
      checks++;
      if ({done, ready} !== 2'b01) begin
        errors++;
        $display("FAIL basic_pulse_end %0d/%0d: got done=%b ready=%b, required done=0 ready=1", ta[i], tb[i], done, ready);
      end
    end
    // Outputs hold while idle (last op 15/1).
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({ready, done, quotient, remainder, divide_by_zero} !== {1'b1, 1'b0, W'(15), W'(0), 1'b0}) begin
        errors++;
        $display("FAIL idle_hold cycle %0d: got rdy=%b done=%b q=%0d r=%0d dbz=%b, required rdy=1 done=0 q=15 r=0 dbz=0",
                 c, ready, done, quotient, remainder, divide_by_zero);
      end
    end
  endtask

  task automatic test_div_zero();
    int   ta[2] = '{9, 6};
    int   tb[2] = '{0, 2};
    int   lat;
    bit   got;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      run_op(ta[i], tb[i], lat, got);
      e = sb.pop_front();
      checks++;
      if (!got || lat !== e.lat) begin
        errors++;
        $display("FAIL dz_latency %0d/%0d: got %0d (seen=%0b), required %0d", ta[i], tb[i], lat, got, e.lat);
      end
      checks++;
      if ({quotient, remainder, divide_by_zero} !== {e.q, e.r, e.dbz}) begin
        errors++;
        $display("FAIL dz_result %0d/%0d: got q=%0d r=%0d dbz=%b, required q=%0d r=%0d dbz=%b",
                 ta[i], tb[i], quotient, remainder, divide_by_zero, e.q, e.r, e.dbz);
      end
    end
  endtask

  task automatic test_ignore_start();
    exp_t         e;
    int           pulses = 0;
    int           first = -1;
    logic [W-1:0] oq = '0;
    logic [W-1:0] orr = '0;
    logic         od = 1'b0;
    @(negedge clk);
    start = 1'b1; dividend = W'(12); divisor = W'(5);
    sb.push_back(model(12, 5));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= W + 6; k++) begin
      if (k == 1) begin start = 1'b1; dividend = W'(1); divisor = W'(1); end
      if (k == 2) begin start = 1'b0; dividend = W'(15); divisor = W'(15); end
      if (done) begin
        pulses++;
        if (first < 0) begin first = k; oq = quotient; orr = remainder; od = divide_by_zero; end
      end
      @(negedge clk);
    end
    e = sb.pop_front();
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL ignore_start_pulses: got %0d, required 1", pulses);
    end
    checks++;
    if (first !== e.lat) begin
      errors++;
      $display("FAIL ignore_start_latency: got %0d, required %0d", first, e.lat);
    end
    checks++;
    if ({oq, orr, od} !== {e.q, e.r, e.dbz}) begin
      errors++;
      $display("FAIL ignore_start_result: got q=%0d r=%0d dbz=%b, required q=%0d r=%0d dbz=%b",
               oq, orr, od, e.q, e.r, e.dbz);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e1, e2;
    int   t[2] = '{-1, -1};
    int   pulses = 0;
    logic [W-1:0] oq[2];
    logic [W-1:0] orr[2];
    @(negedge clk);
    start = 1'b1; dividend = W'(6); divisor = W'(2);
    sb.push_back(model(6, 2));
    sb.push_back(model(6, 2));
    @(posedge clk);
    for (int k = 0; k <= 2 * W + 6; k++) begin
      @(negedge clk);
      if (k == W + 2) start = 1'b0;
      if (done) begin
        if (pulses < 2) begin t[pulses] = k; oq[pulses] = quotient; orr[pulses] = remainder; end
        pulses++;
      end
    end
    start = 1'b0;
    e1 = sb.pop_front();
    e2 = sb.pop_front();
    checks++;
    if (pulses !== 2) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d, required 2", pulses);
    end
    checks++;
    if (t[0] !== e1.lat || t[1] !== (W + 2 + e2.lat)) begin
      errors++;
      $display("FAIL b2b_timing: got %0d,%0d, required %0d,%0d", t[0], t[1], e1.lat, W + 2 + e2.lat);
    end
    checks++;
    if ({oq[0], orr[0], oq[1], orr[1]} !== {e1.q, e1.r, e2.q, e2.r}) begin
      errors++;
      $display("FAIL b2b_result: got %0d r%0d / %0d r%0d, required %0d r%0d / %0d r%0d",
               oq[0], orr[0], oq[1], orr[1], e1.q, e1.r, e2.q, e2.r);
    end
  endtask

  task automatic test_mid_reset();
    int   pulses = 0;
    int   lat;
    bit   got;
    exp_t e;
    @(negedge clk);
    start = 1'b1; dividend = W'(14); divisor = W'(3);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ready, done, quotient, remainder, divide_by_zero} !== {1'b1, 1'b0, W'(0), W'(0), 1'b0}) begin
      errors++;
      $display("FAIL mid_reset_state: got rdy=%b done=%b q=%0d r=%0d dbz=%b, required rdy=1 done=0 q=0 r=0 dbz=0",
               ready, done, quotient, remainder, divide_by_zero);
    end
    rst_n = 1'b1;
    for (int k = 0; k < W + 4; k++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL mid_reset_no_done: got %0d pulses, required 0", pulses);
    end
    run_op(14, 3, lat, got);
    e = sb.pop_front();
    checks++;
    if (!got || lat !== e.lat || {quotient, remainder, divide_by_zero} !== {e.q, e.r, e.dbz}) begin
      errors++;
      $display("FAIL mid_reset_fresh: got lat=%0d q=%0d r=%0d dbz=%b, required lat=%0d q=%0d r=%0d dbz=%b",
               lat, quotient, remainder, divide_by_zero, e.lat, e.q, e.r, e.dbz);
    end
  endtask

  task automatic test_sweep();
    int   lat;
    bit   got;
    exp_t e;
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 0; b < (1 << W); b++) begin
        run_op(a, b, lat, got);
        e = sb.pop_front();
        checks++;
        if (!got || lat !== e.lat || {quotient, remainder, divide_by_zero} !== {e.q, e.r, e.dbz}) begin
          errors++;
          $display("FAIL sweep %0d/%0d: got lat=%0d q=%0d r=%0d dbz=%b, required lat=%0d q=%0d r=%0d dbz=%b",
                   a, b, lat, quotient, remainder, divide_by_zero, e.lat, e.q, e.r, e.dbz);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_mid_reset();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
